// File: rtl/down_counter_pkg.sv
// Shared constants for the free-running down counter.
// The all-ones reset constant is kept 32 bits wide so any counter width can truncate it to its own all-ones value.
package down_counter_pkg;

    localparam int unsigned COUNTER_WIDTH     = 4;
    localparam logic [31:0] COUNTER_RESET_VAL = 32'hFFFF_FFFF;

endpackage

// File: rtl/down_counter.sv
// Free-running modulo-2^WIDTH down counter with a zero decode and a registered wrap pulse.
// Counting is unconditional while rest is high; rest low asynchronously reloads RESET_VAL.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = COUNTER_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(COUNTER_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rest,
    output logic [WIDTH-1:0] cnt,
    output logic             zero,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;

    // Underflow from 0 lands on all-ones naturally; wrap marks the cycle that holds that result.
    always_comb begin
        cnt_d  = cnt_q - WIDTH'(1);
        wrap_d = (cnt_q == '0);
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            cnt_q  <= RESET_VAL;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;
    assign zero = (cnt_q == '0);

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter: default 4-bit instance plus a WIDTH=3, RESET_VAL=5 instance.
// Outputs are sampled on the falling clock edge, half a period away from the active edge.
module tb_down_counter;

    logic       clk;
    logic       rest;
    logic       rest_b;
    logic [3:0] cnt;
    logic       zero;
    logic       wrap;
    logic [2:0] cnt_b;
    logic       zero_b;
    logic       wrap_b;

    int checks   = 0;
    int failures = 0;

    down_counter u_dut (
        .clk  (clk),
        .rest (rest),
        .cnt  (cnt),
        .zero (zero),
        .wrap (wrap)
    );

    down_counter #(.WIDTH(3), .RESET_VAL(3'd5)) u_dut_w3 (
        .clk  (clk),
        .rest (rest_b),
        .cnt  (cnt_b),
        .zero (zero_b),
        .wrap (wrap_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        int          exp_cnt;
        int          wrap_seen;
        logic        exp_wrap;

        rest   = 1'b0;
        rest_b = 1'b0;

        // Reset hold for 100 ns: five falling edges, all at the reset value.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_cnt",  32'(cnt),  32'd15);
            check("hold_zero", 32'(zero), 32'd0);
            check("hold_wrap", 32'(wrap), 32'd0);
        end
        rest = 1'b1;

        // Count 14 down to 0; zero only on the last step.
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            check("seq_cnt",  32'(cnt),  32'(15 - i));
            check("seq_zero", 32'(zero), (i == 15) ? 32'd1 : 32'd0);
            check("seq_wrap", 32'(wrap), 32'd0);
        end

        @(negedge clk);
        check("wrap_cnt",  32'(cnt),  32'd15);
        check("wrap_hi",   32'(wrap), 32'd1);
        check("wrap_zero", 32'(zero), 32'd0);
        @(negedge clk);
        check("after_wrap_cnt", 32'(cnt),  32'd14);
        check("after_wrap_lo",  32'(wrap), 32'd0);

        // Run down to 7, then assert reset between edges.
        for (int i = 0; i < 7; i++) @(negedge clk);
        check("pre_abort_cnt", 32'(cnt), 32'd7);
        rest = 1'b0;
        #1;
        check("abort_cnt",  32'(cnt),  32'd15);
        check("abort_wrap", 32'(wrap), 32'd0);
        check("abort_zero", 32'(zero), 32'd0);
        @(negedge clk);
        check("abort_hold_cnt", 32'(cnt), 32'd15);

        // Long run: 20 edges after release, tracking with a modulo-16 model.
        rest      = 1'b1;
        exp_cnt   = 15;
        wrap_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp_wrap = (exp_cnt == 0);
            exp_cnt  = (exp_cnt + 15) % 16;
            check("long_cnt",  32'(cnt),  32'(exp_cnt));
            check("long_wrap", 32'(wrap), 32'(exp_wrap));
            check("long_zero", 32'(zero), (exp_cnt == 0) ? 32'd1 : 32'd0);
            if (wrap === 1'b1) wrap_seen++;
        end
        check("long_final_cnt",  32'(cnt),  32'd11);
        check("long_wrap_count", 32'(wrap_seen), 32'd1);

        // WIDTH=3, RESET_VAL=5 instance: 5,4,3,2,1,0,7,6.
        check("w3_reset_cnt",  32'(cnt_b),  32'd5);
        check("w3_reset_wrap", 32'(wrap_b), 32'd0);
        check("w3_reset_zero", 32'(zero_b), 32'd0);
        rest_b = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            case (i)
                1: check("w3_cnt", 32'(cnt_b), 32'd4);
                2: check("w3_cnt", 32'(cnt_b), 32'd3);
                3: check("w3_cnt", 32'(cnt_b), 32'd2);
                4: check("w3_cnt", 32'(cnt_b), 32'd1);
                5: check("w3_cnt", 32'(cnt_b), 32'd0);
                6: check("w3_cnt", 32'(cnt_b), 32'd7);
                default: check("w3_cnt", 32'(cnt_b), 32'd6);
            endcase
            check("w3_wrap", 32'(wrap_b), (i == 6) ? 32'd1 : 32'd0);
            check("w3_zero", 32'(zero_b), (i == 5) ? 32'd1 : 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter RESET_VAL, default all-ones (4'hF at WIDTH=4), the value loaded on reset.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rest, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have port cnt, output, WIDTH bits, the registered current count.
REQ-006 The block SHALL have port zero, output, 1 bit, high whenever cnt equals 0 (combinational decode of the cnt register).
REQ-007 The block SHALL have port wrap, output, 1 bit, a registered one-cycle pulse marking the 0 -> all-ones transition.
REQ-008 The block SHALL have no other ports; counting is unconditional while out of reset.

Function
REQ-009 The block SHALL decrement cnt by exactly 1 on each rising clk edge while rest is high.
REQ-010 The block SHALL compute the decrement modulo 2^WIDTH, so cnt = 0 is followed by cnt = 2^WIDTH-1 (0 -> 15 at WIDTH=4) with no stall.
REQ-011 The block SHALL keep the first decrement after reset release on the first rising edge at which rest is sampled high (latency 1 cycle, no extra wait states).
REQ-012 The block SHALL drive wrap high for exactly the one cycle in which cnt holds 2^WIDTH-1 as a result of wrapping from 0; wrap SHALL be low in all other cycles, including the cycle after reset when cnt holds RESET_VAL.
REQ-013 The block SHALL drive zero high in exactly the cycle in which cnt = 0; with RESET_VAL = 15 this is 15 cycles after reset release, repeating every 2^WIDTH cycles.
REQ-014 The block SHALL derive all outputs from flops or decoding of flops only, with no combinational path from any input to any output.

Reset
REQ-015 The block SHALL, while rest is low, force cnt = RESET_VAL, wrap = 0 and zero = (RESET_VAL == 0), asynchronously and regardless of clk.
REQ-016 The block SHALL abort the count immediately if rest is asserted mid-count; no partial or next value is retained.
REQ-017 The block SHALL leave cnt at RESET_VAL on the rising edge coincident with rest deassertion (rest still low at the edge), and begin decrementing on the next edge.

Structure
REQ-018 The block SHALL take the default width constant (COUNTER_WIDTH = 4) and the default reset-value constant from the shared package down_counter_pkg.
REQ-019 The block SHALL be implemented as a single module with no sub-modules: one register process for cnt and wrap, and one continuous decode for zero.

Verification
REQ-020 The bench SHALL cover reset hold: rest = 0 for 100 ns with a 20 ns clk period -> cnt = 15, zero = 0, wrap = 0 throughout.
REQ-021 The bench SHALL cover the count sequence: release rest and clock 15 edges -> cnt = 14, 13, ... 1, 0, with zero = 1 only at cnt = 0.
REQ-022 The bench SHALL cover wrap-around: the edge after cnt = 0 -> cnt = 15 with wrap = 1 for exactly one cycle, and the next edge -> cnt = 14 with wrap = 0.
REQ-023 The bench SHALL cover mid-count reset: assert rest at cnt = 7, between edges -> cnt = 15 immediately, before the next clk edge.
REQ-024 The bench SHALL cover a long run: 400 ns after release (20 edges) -> cnt = 11, with exactly one wrap pulse seen.
REQ-025 The bench SHALL cover a parameter sweep: WIDTH = 3 with RESET_VAL = 5 -> sequence 5, 4, 3, 2, 1, 0, 7, with wrap pulsing at 7.
